// File: rtl/gpio_key_pkg.sv
// Shared definitions for the GPIO key conditioner: debounce FSM encoding and 50 MHz timing defaults.
package gpio_key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } keyState_t;

    localparam int DEBOUNCE_CYC_DEF = 500000;
    localparam int CNT_W_DEF        = 20;
    localparam int REPEAT_DLY_DEF   = 25000000;
    localparam int REPEAT_PER_DEF   = 5000000;

endpackage

// File: rtl/key_debounce_ch.sv
// One GPIO key channel: 2-flop synchroniser, debounce FSM and registered level/press/release outputs.
// Long-press auto-repeat is compiled in only when GPIO_KEY_REPEAT_EN is defined.
module key_debounce_ch
    import gpio_key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int CNT_W        = CNT_W_DEF
`ifdef GPIO_KEY_REPEAT_EN
    ,
    parameter int REPEAT_DLY   = REPEAT_DLY_DEF,
    parameter int REPEAT_PER   = REPEAT_PER_DEF
`endif
) (
    input  logic iCLK,
    input  logic iRSTn,
    input  logic iDATA,
    output logic oLEVEL,
    output logic oPRESS,
    output logic oRELEASE
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

`ifdef GPIO_KEY_REPEAT_EN
    localparam int RCNT_W = $clog2(REPEAT_DLY + 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST   = RCNT_W'(REPEAT_DLY - 1);
    localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(REPEAT_DLY - REPEAT_PER);
    logic [RCNT_W-1:0] r_rcnt;
`endif

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_vld;
    logic             r_armed;
    keyState_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;

    assign w_s = r_sync2;

    // r_armed stays low until a genuinely sampled "released" level is seen, so a key held
    // through reset is accepted silently instead of producing a spurious press pulse.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= iDATA;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            if (r_vld[1] && w_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            oLEVEL   <= 1'b0;
            oPRESS   <= 1'b0;
            oRELEASE <= 1'b0;
`ifdef GPIO_KEY_REPEAT_EN
            r_rcnt   <= '0;
`endif
        end else begin
            oPRESS   <= 1'b0;
            oRELEASE <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_s) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (w_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                        oLEVEL  <= 1'b1;
                        oPRESS  <= r_armed;
`ifdef GPIO_KEY_REPEAT_EN
                        r_rcnt  <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (w_s) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
`ifdef GPIO_KEY_REPEAT_EN
                    // Reloading below the terminal value spaces later pulses REPEAT_PER apart.
                    else if (r_rcnt == RCNT_LAST) begin
                        oPRESS <= r_armed;
                        r_rcnt <= RCNT_RELOAD;
                    end else begin
                        r_rcnt <= r_rcnt + RCNT_W'(1);
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (!w_s) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                        oLEVEL   <= 1'b0;
                        oRELEASE <= 1'b1;
`ifdef GPIO_KEY_REPEAT_EN
                        r_rcnt   <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/gpio_key_conditioner.sv
// GPIO_0 key conditioner: WL independent debounced channels with level and press/release pulses.
// Define GPIO_KEY_REPEAT_EN to add long-press auto-repeat on oPRESS.
module gpio_key_conditioner
    import gpio_key_pkg::*;
#(
    parameter int WL           = 4,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int REPEAT_DLY   = REPEAT_DLY_DEF,
    parameter int REPEAT_PER   = REPEAT_PER_DEF
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic [WL-1:0] iDATA,
    output logic [WL-1:0] oLEVEL,
    output logic [WL-1:0] oPRESS,
    output logic [WL-1:0] oRELEASE
);

    if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > (2 ** CNT_W) - 1) begin : g_bad_debounce
        $error("gpio_key_conditioner: DEBOUNCE_CYC out of range for CNT_W");
    end

    if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_repeat
        $error("gpio_key_conditioner: repeat timings must be positive");
    end

`ifdef GPIO_KEY_REPEAT_EN
    // The repeat counter reloads to REPEAT_DLY-REPEAT_PER, so the period cannot exceed the delay.
    if (REPEAT_PER > REPEAT_DLY) begin : g_bad_repeat_order
        $error("gpio_key_conditioner: REPEAT_PER must not exceed REPEAT_DLY");
    end
`endif

    for (genvar g = 0; g < WL; g++) begin : g_ch
`ifdef GPIO_KEY_REPEAT_EN
        key_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .CNT_W        (CNT_W),
            .REPEAT_DLY   (REPEAT_DLY),
            .REPEAT_PER   (REPEAT_PER)
        ) u_ch (
            .iCLK     (iCLK),
            .iRSTn    (iRSTn),
            .iDATA    (iDATA[g]),
            .oLEVEL   (oLEVEL[g]),
            .oPRESS   (oPRESS[g]),
            .oRELEASE (oRELEASE[g])
        );
`else
        key_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .CNT_W        (CNT_W)
        ) u_ch (
            .iCLK     (iCLK),
            .iRSTn    (iRSTn),
            .iDATA    (iDATA[g]),
            .oLEVEL   (oLEVEL[g]),
            .oPRESS   (oPRESS[g]),
            .oRELEASE (oRELEASE[g])
        );
`endif
    end

endmodule

// File: doc/gpio_key_conditioner.md
Name: gpio_key_conditioner

Overview:
- Input conditioning stage directly upstream of the top-level Controller, clock, Timer and stop_watch key inputs.
- Takes the raw, asynchronous, active-low Arduino button lines on GPIO_0.
- Per channel it synchronises, debounces and edge-detects each line, producing a clean pressed level plus single-cycle press/release pulses on CLOCK_50.
- Replaces the plain D_REG on GPIO_0, so mode and key logic see one event per physical press.

Parameters:
WL, 4, number of GPIO key channels (GPIO_0 width).
DEBOUNCE_CYC, 500000, cycles a line must be stable before a state change is accepted (10 ms at 50 MHz); legal range 1..2^CNT_W-1.
CNT_W, 20, debounce counter width.
REPEAT_DLY, 25000000, long-press delay before the first auto-repeat (0.5 s); used only with the optional feature.
REPEAT_PER, 5000000, auto-repeat period (0.1 s); used only with the optional feature.

Ports:
iCLK  input  1  system clock (CLOCK_50).
iRSTn  input  1  asynchronous active-low reset (KEY[0]).
iDATA  input  WL  raw GPIO_0 lines; active-low (0 = pressed); asynchronous to iCLK.
oLEVEL  output  WL  debounced pressed level; active-high.
oPRESS  output  WL  one-cycle pulse per accepted press, plus auto-repeat pulses when the optional feature is compiled in.
oRELEASE  output  WL  one-cycle pulse per accepted release.

Behaviour:
- Reset: iRSTn low asynchronously forces all channels to IDLE.
  - Synchroniser flops reset to 1 (released).
  - Counters reset to 0.
  - oLEVEL, oPRESS and oRELEASE reset to 0.
  - Reset mid-debounce or mid-press discards the event; no pulse is emitted on reset release, even if a line is held low.
- Synchroniser: 2 flops per channel; s = second-flop output. All decisions use s only.
- Per-channel FSM states: IDLE (released, stable), PRESS_WAIT, PRESSED (stable), RELEASE_WAIT.
  - IDLE: s=0 -> PRESS_WAIT, counter=0.
  - PRESS_WAIT: s=1 -> IDLE (glitch rejected, no output). s=0 with counter<DEBOUNCE_CYC-1 -> counter+1. s=0 with counter==DEBOUNCE_CYC-1 -> PRESSED.
  - PRESSED: s=1 -> RELEASE_WAIT, counter=0.
  - RELEASE_WAIT: s=0 -> PRESSED (bounce rejected, oLEVEL stays 1). s=1 with counter==DEBOUNCE_CYC-1 -> IDLE.
- Outputs are registered.
  - On the PRESS_WAIT->PRESSED transition, oLEVEL rises and oPRESS is high for exactly the following cycle.
  - On the RELEASE_WAIT->IDLE transition, oLEVEL falls and oRELEASE is high for exactly the following cycle.
- Latency: raw edge at clock k, stable thereafter -> s changes at k+2 -> output at cycle k+2+DEBOUNCE_CYC.
- Pulse rules:
  - oPRESS and oRELEASE are never high together on one channel.
  - Minimum spacing between press and release pulses of a channel is DEBOUNCE_CYC cycles.
- Channels are fully independent; simultaneous presses on several channels yield simultaneous pulses.
- The counter never wraps: it saturates at DEBOUNCE_CYC-1 and is cleared on every state entry.
- DEBOUNCE_CYC=1: acceptance happens on the first cycle s differs; latency is 3 cycles.

Optional Feature:
- Macro: GPIO_KEY_REPEAT_EN.
- Defined: in PRESSED, a second per-channel counter starts at 0 on entry.
  - When it reaches REPEAT_DLY-1, an extra oPRESS pulse is issued.
  - Thereafter an extra pulse is issued every REPEAT_PER cycles while PRESSED.
  - The counter is frozen in RELEASE_WAIT, resumes if the bounce returns to PRESSED, and is cleared on IDLE.
  - Intended for fast time-set on the clock/Timer keys.
- Undefined: no repeat counter is instantiated, and exactly one oPRESS is issued per press; REPEAT_DLY and REPEAT_PER are ignored.

Decomposition:
- Shared package gpio_key_pkg holds:
  - the FSM state encoding constants (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3);
  - the default DEBOUNCE_CYC, REPEAT_DLY and REPEAT_PER values at 50 MHz.
- Sub-module key_debounce_ch holds one channel's synchroniser, FSM, counters and output registers.
- The top instantiates WL copies via a generate loop.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DLY=20, REPEAT_PER=8, WL=4):
1. Reset held with iDATA=4'b0000, then released -> all outputs 0 at release; oLEVEL=4'b1111 after 6 cycles with no oPRESS pulse. Expected because the sync flops reset to 1, so the held line is seen as a fresh falling edge.
2. iDATA[0] 1->0 at cycle 10, held -> oPRESS[0]=1 only at cycle 16; oLEVEL[0]=1 from cycle 16.
3. iDATA[1] low for 3 cycles, then high; repeat 5 times -> oLEVEL[1], oPRESS[1] and oRELEASE[1] stay 0 throughout.
4. Channel 2 pressed and stable, release with a 2-cycle 1/0 bounce, then stable high -> exactly one oRELEASE[2], 4+2 cycles after the last bounce edge; oLEVEL[2] held at 1 during the bounce.
5. Channels 0 and 3 pressed on the same cycle; iRSTn pulsed low mid-PRESS_WAIT -> outputs go 0 immediately; no pulses until a new stable press.
6. With GPIO_KEY_REPEAT_EN, hold channel 0 for 50 cycles after acceptance -> oPRESS[0] at acceptance, +20, +28, +36, +44; without the macro -> only the acceptance pulse.
